clkbuf_freq_monitor: RTL and testbench



---
 rtl/clkbuf_freq_monitor.sv | 169 ++++++++++++++++
 tb/tb_clkbuf_freq_monitor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkbuf_freq_monitor.sv
// clkbuf_freq_monitor
// Counts rising edges of an asynchronous clock-tree leaf (A) over a fixed
// window of reference cycles (CLK) and reports the count with LOW/HIGH range
// flags. Observability only; drives nothing in the clock path.
//
// Optional feature macro: CLKMON_STUCK_EN
//   defined   - idle counter flags loss of activity on A (STUCK) mid-window
//   undefined - no idle counter, STUCK is constant 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | counters held at 0, edges ignored, waits for EN
// MEASURE | counts CLK cycles of the window and synchronized A rises
// REPORT  | one cycle: latch COUNT/LOW/HIGH, pulse VALID next cycle

module clkbuf_freq_monitor #(
    parameter int WINDOW      = 32,
    parameter int CNT_W       = 8,
    parameter int MIN_EDGES   = 6,
    parameter int MAX_EDGES   = 10,
    parameter int STUCK_LIMIT = 12
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             A,
    output logic [CNT_W-1:0] COUNT,
    output logic             VALID,
    output logic             LOW,
    output logic             HIGH,
    output logic             STUCK
);

    localparam int                WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_EDGES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    state_t            state;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              s1, s2, s3;
    logic              rise;

    assign rise = s2 & ~s3;

    // Two-flop synchronizer plus history flop; free-running in every state.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= A;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Window sequencing, edge counting and registered report outputs.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            COUNT    <= '0;
            VALID    <= 1'b0;
            LOW      <= 1'b0;
            HIGH     <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    if (EN) begin
                        state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (!EN) begin
                        // Abort: partial window is discarded, outputs hold.
                        state    <= ST_IDLE;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        if (rise && (edge_cnt != CNT_MAX)) begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                        if (win_cnt == WIN_LAST) begin
                            state <= ST_REPORT;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    // Edges seen in this cycle are dropped; period is WINDOW+1.
                    COUNT    <= edge_cnt;
                    LOW      <= (edge_cnt < MIN_C);
                    HIGH     <= (edge_cnt > MAX_C);
                    VALID    <= 1'b1;
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    state    <= EN ? ST_MEASURE : ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

`ifdef CLKMON_STUCK_EN
    localparam int                STK_W   = $clog2(STUCK_LIMIT + 1);
    localparam logic [STK_W-1:0]  STK_LIM = STK_W'(STUCK_LIMIT);

    logic [STK_W-1:0] idle_cnt;
    logic             toggle;

    assign toggle = s2 ^ s3;

    // Activity-loss detector: counts MEASURE cycles without any A transition.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            idle_cnt <= '0;
            STUCK    <= 1'b0;
        end else begin
            case (state)
                ST_MEASURE: begin
                    if (!EN) begin
                        idle_cnt <= '0;
                        STUCK    <= 1'b0;
                    end else if (toggle) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != STK_LIM) begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (idle_cnt == STK_LIM - 1'b1) begin
                            STUCK <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    idle_cnt <= '0;
                    if (!EN) begin
                        STUCK <= 1'b0;
                    end
                end
                default: begin
                    idle_cnt <= '0;
                    STUCK    <= 1'b0;
                end
            endcase
        end
    end
`else
    assign STUCK = 1'b0;
`endif

endmodule

// File: tb/tb_clkbuf_freq_monitor.sv
// Testbench for clkbuf_freq_monitor: table of A periods with expected
// reports, directed abort / reset / stuck sequences, and randomized A and EN
// checked every cycle against a window-arithmetic reference model.

module tb_clkbuf_freq_monitor;

    localparam int W    = 32;
    localparam int CW   = 8;
    localparam int MINE = 6;
    localparam int MAXE = 10;
    localparam int SL   = 12;
    localparam int MAXC = 16384;

    logic          CLK = 1'b0;
    logic          RN  = 1'b0;
    logic          EN  = 1'b0;
    logic          A   = 1'b0;
    logic [CW-1:0] COUNT;
    logic          VALID, LOW, HIGH, STUCK;

    clkbuf_freq_monitor #(
        .WINDOW(W), .CNT_W(CW), .MIN_EDGES(MINE), .MAX_EDGES(MAXE), .STUCK_LIMIT(SL)
    ) dut (
        .CLK(CLK), .RN(RN), .EN(EN), .A(A),
        .COUNT(COUNT), .VALID(VALID), .LOW(LOW), .HIGH(HIGH), .STUCK(STUCK)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // cyc = number of rising CLK edges so far (index of the next edge).
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // A stimulus: 0 = hold a_hold, 1 = square wave toggling every a_half
    // cycles at the falling CLK edge, 2 = random level each cycle.
    int a_mode = 0;
    int a_half = 2;
    bit a_hold = 1'b0;
    int a_ph   = 0;

    always @(negedge CLK) begin
        if (a_mode == 1) begin
            if (a_ph + 1 >= a_half) begin
                A    <= ~A;
                a_ph <= 0;
            end else begin
                a_ph <= a_ph + 1;
            end
        end else if (a_mode == 2) begin
            A <= 1'($urandom_range(0, 1));
        end else begin
            A <= a_hold;
        end
    end

    // Reference model: record A as seen at every CLK edge; a window opened by
    // EN at edge k covers the rising transitions into samples k-1..k+W-2
    // (two synchronizer stages of delay) and is reported at edge k+W+1.
    // Samples taken before the end of reset read as 0.
    bit samp [MAXC];
    int floor_c = 0;
    typedef enum {M_IDLE, M_MEAS, M_REP} mph_t;
    mph_t ph = M_IDLE;
    int start = 0;
    logic [CW-1:0] e_count = '0;
    logic e_valid = 1'b0, e_low = 1'b0, e_high = 1'b0;

    function automatic bit sv(input int j);
        if (j < floor_c || j < 0 || j >= MAXC) return 1'b0;
        return samp[j];
    endfunction

    function automatic int rises(input int lo, input int hi);
        int c = 0;
        for (int j = lo; j <= hi; j++)
            if (sv(j) && !sv(j - 1)) c++;
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        return c;
    endfunction

    always @(posedge CLK or negedge RN) begin
        if (!RN) begin
            ph      <= M_IDLE;
            e_count <= '0;
            e_valid <= 1'b0;
            e_low   <= 1'b0;
            e_high  <= 1'b0;
            floor_c <= cyc + 1;
        end else begin
            if (cyc < MAXC) samp[cyc] <= A;
            e_valid <= 1'b0;
            case (ph)
                M_IDLE: if (EN) begin
                    ph    <= M_MEAS;
                    start <= cyc;
                end
                M_MEAS: begin
                    if (!EN) ph <= M_IDLE;
                    else if (cyc == start + W) ph <= M_REP;
                end
                default: begin
                    e_count <= CW'(rises(start - 1, start + W - 2));
                    e_low   <= (rises(start - 1, start + W - 2) < MINE);
                    e_high  <= (rises(start - 1, start + W - 2) > MAXE);
                    e_valid <= 1'b1;
                    if (EN) begin
                        ph    <= M_MEAS;
                        start <= cyc;
                    end else begin
                        ph <= M_IDLE;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        chk("valid", int'(VALID), int'(e_valid));
        chk("count", int'(COUNT), int'(e_count));
        chk("low",   int'(LOW),   int'(e_low));
        chk("high",  int'(HIGH),  int'(e_high));
`ifndef CLKMON_STUCK_EN
        chk("stuck_tied", int'(STUCK), 0);
`endif
    end

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (VALID === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("valid_timeout", 0, 1);
    endtask

    typedef struct {
        int half;
        int exp_count;
        bit exp_low;
        bit exp_high;
    } vec_t;

    vec_t vt [5];

    initial begin
        int en_cyc, v1, v2;

        vt[0] = '{half: 2, exp_count: 8,  exp_low: 1'b0, exp_high: 1'b0};
        vt[1] = '{half: 4, exp_count: 4,  exp_low: 1'b1, exp_high: 1'b0};
        vt[2] = '{half: 1, exp_count: 16, exp_low: 1'b0, exp_high: 1'b1};
        vt[3] = '{half: 8, exp_count: 2,  exp_low: 1'b1, exp_high: 1'b0};
        vt[4] = '{half: 0, exp_count: 0,  exp_low: 1'b1, exp_high: 1'b0};

        // Reset values
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_count", int'(COUNT), 0);
        chk("rst_valid", int'(VALID), 0);
        chk("rst_low",   int'(LOW),   0);
        chk("rst_high",  int'(HIGH),  0);
        chk("rst_stuck", int'(STUCK), 0);
        @(negedge CLK);
        #2 RN = 1'b1;

        // Table of A periods
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (vt[i].half == 0) begin
                a_mode = 0;
                a_hold = 1'b0;
            end else begin
                a_mode = 1;
                a_half = vt[i].half;
            end
            if (i == 0) begin
                EN     = 1'b1;
                en_cyc = cyc;
            end
            wait_valid(v1);
            if (i == 0) chk("first_valid_latency", v1 - en_cyc, W + 2);
            wait_valid(v2);
            chk("valid_spacing", v2 - v1, W + 1);
            chk("tbl_count", int'(COUNT), vt[i].exp_count);
            chk("tbl_low",   int'(LOW),   int'(vt[i].exp_low));
            chk("tbl_high",  int'(HIGH),  int'(vt[i].exp_high));
        end

        // Abort mid-window: no VALID, outputs hold, restart latency
        a_mode = 1;
        a_half = 2;
        wait_valid(v1);
        wait_valid(v1);
        repeat (19) @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            chk("abort_no_valid", int'(VALID), 0);
        end
        chk("abort_count", int'(COUNT), 8);
        chk("abort_low",   int'(LOW),   0);
        chk("abort_high",  int'(HIGH),  0);
        EN     = 1'b1;
        en_cyc = cyc;
        wait_valid(v1);
        chk("reraise_latency", v1 - en_cyc, W + 2);

        // Randomized A with occasional EN drops
        a_mode = 2;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 59) == 0) EN = ~EN;
        end
        EN = 1'b1;

        // Reset in the middle of a window
        a_mode = 1;
        a_half = 2;
        wait_valid(v1);
        wait_valid(v1);
        repeat (19) @(negedge CLK);
        #2 RN = 1'b0;
        #1;
        chk("midrst_count", int'(COUNT), 0);
        chk("midrst_valid", int'(VALID), 0);
        chk("midrst_low",   int'(LOW),   0);
        chk("midrst_high",  int'(HIGH),  0);
        @(negedge CLK);
        @(negedge CLK);
        #2 RN  = 1'b1;
        en_cyc = cyc;
        wait_valid(v1);
        chk("postrst_latency", v1 - en_cyc, W + 2);
        chk("postrst_count", int'(COUNT), 8);

`ifdef CLKMON_STUCK_EN
        // Activity loss with A held low
        @(negedge CLK);
        EN     = 1'b0;
        a_mode = 0;
        a_hold = 1'b0;
        repeat (6) @(negedge CLK);
        EN = 1'b1;
        repeat (11) @(negedge CLK);
        chk("stuck_early", int'(STUCK), 0);
        repeat (2) @(negedge CLK);
        chk("stuck_set", int'(STUCK), 1);
        EN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("stuck_clear", int'(STUCK), 0);
`endif

        @(negedge CLK);
        EN = 1'b0;
        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
